// File: rtl/mem_resp_pkg.sv
// Shared encodings for the MEM completion stage: write-back select, load/store types,
// and the alignment rule used to spot accesses the issuer suppresses.
package mem_resp_pkg;

    localparam logic [1:0] WD_RAM     = 2'b01;

    localparam logic [2:0] RAM_EXT_W  = 3'b000;
    localparam logic [2:0] RAM_EXT_B  = 3'b001;
    localparam logic [2:0] RAM_EXT_BU = 3'b010;
    localparam logic [2:0] RAM_EXT_H  = 3'b011;
    localparam logic [2:0] RAM_EXT_HU = 3'b100;

    localparam logic [3:0] RAM_WE_N   = 4'h0;
    localparam logic [3:0] RAM_WE_B   = 4'h1;
    localparam logic [3:0] RAM_WE_H   = 4'h3;
    localparam logic [3:0] RAM_WE_W   = 4'hF;

    // Loads are classified by ext_op, stores by their byte-enable pattern.
    function automatic logic is_misaligned(input logic [2:0] ext_op,
                                           input logic [3:0] we,
                                           input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (we == RAM_WE_N) begin
            case (ext_op)
                RAM_EXT_H, RAM_EXT_HU: mis = off[0];
                RAM_EXT_W:             mis = (off != 2'b00);
                default:               mis = 1'b0;
            endcase
        end else begin
            case (we)
                RAM_WE_H: mis = off[0];
                RAM_WE_W: mis = (off != 2'b00);
                default:  mis = 1'b0;
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_resp_load_align.sv
// Lane select plus sign/zero extension of a word-aligned read word.
// Purely combinational so the cache refill path can reuse it.
module load_align
    import mem_resp_pkg::*;
(
    input  logic [2:0]  ext_op,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[{off, 3'b000} +: 8];
        half_lane = off[1] ? word[31:16] : word[15:0];
        case (ext_op)
            RAM_EXT_B:  result = {{24{byte_lane[7]}}, byte_lane};
            RAM_EXT_BU: result = {24'h0, byte_lane};
            RAM_EXT_H:  result = {{16{half_lane[15]}}, half_lane};
            RAM_EXT_HU: result = {16'h0, half_lane};
            default:    result = word;
        endcase
    end

endmodule

// File: rtl/mem_resp.sv
// MEM-stage load/store completion: tracks the access in flight, stalls upstream,
// aligns load data and flags misaligned accesses (mem_ale/mem_badv under MEM_RESP_ALE_EN).
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int TIMEOUT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic [1:0]           mem_wd_sel,
    input  logic [31:0]          mem_ram_addr,
    input  logic [2:0]           mem_ram_ext_op,
    input  logic [3:0]           mem_ram_we,
    input  logic                 da_rvalid,
    input  logic [31:0]          da_rdata,
    output logic [31:0]          mem_rdata,
    output logic                 mem_done,
    output logic                 mem_stall,
    output logic                 mem_ale,
    output logic [31:0]          mem_badv,
    output logic [TIMEOUT_W-1:0] ld_wait_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ST   = 2'd1;
    localparam logic [1:0] S_LD   = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]  state, state_nxt;
    logic        start;
    logic        ram_start;
    logic        mis;
    logic        done_nxt;
    logic        ld_capture;
    logic [2:0]  ctx_ext;
    logic [3:0]  ctx_we;
    logic [31:0] ctx_addr;
    logic [31:0] aligned;

    // start mirrors the issuer's request pulse: one cycle after EX hands over.
    assign ram_start = start && (mem_wd_sel == WD_RAM);
    assign mis       = is_misaligned(mem_ram_ext_op, mem_ram_we, mem_ram_addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            start <= 1'b0;
        end else begin
            state <= state_nxt;
            start <= ex_valid;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (ram_start) begin
                if (mis)                         state_nxt = S_ERR;
                else if (mem_ram_we != RAM_WE_N) state_nxt = S_ST;
                else                             state_nxt = S_LD;
            end
            S_ST, S_ERR: state_nxt = S_IDLE;
            S_LD:        if (da_rvalid) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ld_capture = (state == S_LD) && da_rvalid;
        done_nxt   = (state == S_ST) || (state == S_ERR) || ld_capture;
        mem_stall  = ram_start || (state != S_IDLE);
    end

    // Context is only taken from IDLE, so a stray start mid-access cannot corrupt it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctx_ext  <= '0;
            ctx_we   <= '0;
            ctx_addr <= '0;
        end else if (state == S_IDLE && ram_start) begin
            ctx_ext  <= mem_ram_ext_op;
            ctx_we   <= mem_ram_we;
            ctx_addr <= mem_ram_addr;
        end
    end

    load_align u_align (
        .ext_op (ctx_ext),
        .off    (ctx_addr[1:0]),
        .word   (da_rdata),
        .result (aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_done    <= 1'b0;
            mem_rdata   <= '0;
            ld_wait_cnt <= '0;
        end else begin
            mem_done <= done_nxt;
            if (ld_capture)
                mem_rdata <= aligned;
`ifndef MEM_RESP_ALE_EN
            else if (state == S_ERR && ctx_we == RAM_WE_N)
                mem_rdata <= '0;
`endif
            if (state == S_IDLE && state_nxt == S_LD)
                ld_wait_cnt <= '0;
            else if (state == S_LD && !da_rvalid && ld_wait_cnt != '1)
                ld_wait_cnt <= ld_wait_cnt + 1'b1;
        end
    end

`ifdef MEM_RESP_ALE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ale  <= 1'b0;
            mem_badv <= '0;
        end else begin
            mem_ale <= (state == S_ERR);
            if (state == S_ERR)
                mem_badv <= ctx_addr;
        end
    end
`else
    logic unused_ctx_addr;
    assign unused_ctx_addr = ^ctx_addr[31:2];
    assign mem_ale  = 1'b0;
    assign mem_badv = '0;
`endif

endmodule

// File: tb/tb_mem_resp.sv
// Randomized bench for mem_resp against a cycle-count/arithmetic reference of the access rules.
module tb_mem_resp;
    import mem_resp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [1:0]  mem_wd_sel = 2'b00;
    logic [31:0] mem_ram_addr = '0;
    logic [2:0]  mem_ram_ext_op = '0;
    logic [3:0]  mem_ram_we = '0;
    logic        da_rvalid = 1'b0;
    logic [31:0] da_rdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_stall;
    logic        mem_ale;
    logic [31:0] mem_badv;
    logic [7:0]  ld_wait_cnt;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_badv = '0;
    logic [7:0]  exp_cnt = '0;

    mem_resp #(.TIMEOUT_W(8)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_wd_sel(mem_wd_sel),
        .mem_ram_addr(mem_ram_addr), .mem_ram_ext_op(mem_ram_ext_op), .mem_ram_we(mem_ram_we),
        .da_rvalid(da_rvalid), .da_rdata(da_rdata), .mem_rdata(mem_rdata),
        .mem_done(mem_done), .mem_stall(mem_stall), .mem_ale(mem_ale),
        .mem_badv(mem_badv), .ld_wait_cnt(ld_wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    // Access size in bytes; misaligned means the address is not a multiple of it.
    function automatic bit ref_mis(input logic [2:0] e, input logic [3:0] w, input logic [31:0] a);
        int size;
        if (w != RAM_WE_N) size = (w == RAM_WE_W) ? 4 : (w == RAM_WE_H) ? 2 : 1;
        else size = (e == RAM_EXT_W) ? 4 : (e == RAM_EXT_H || e == RAM_EXT_HU) ? 2 : 1;
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] e, input logic [31:0] a, input logic [31:0] word);
        int b, h;
        b = (word >> (8 * (a % 4))) & 32'hFF;
        h = (word >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (e)
            RAM_EXT_B:  return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            RAM_EXT_BU: return 32'(b);
            RAM_EXT_H:  return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            RAM_EXT_HU: return 32'(h);
            default:    return word;
        endcase
    endfunction

    // Runs one access from EX handover to completion, checking done/stall every cycle.
    // With overlap set, ex_valid is raised in the previous access's done cycle.
    task automatic access(input logic [1:0] wd, input logic [2:0] e, input logic [3:0] w,
                          input logic [31:0] a, input logic [31:0] word, input int dly,
                          input bit overlap);
        bit ram, ld, mis, ale_exp;
        int done_c;
        ram = (wd == WD_RAM);
        ld  = (w == RAM_WE_N);
        mis = ram && ref_mis(e, w, a);
        done_c = !ram ? 4 : (mis || !ld) ? 3 : 4 + dly;
        if (!overlap) tick;
        ex_valid = 1'b1; da_rvalid = 1'b0;
        mem_wd_sel = wd; mem_ram_ext_op = e; mem_ram_we = w; mem_ram_addr = a;
        if (!overlap) begin
            smp;
            chk("stall_idle", mem_stall, 1'b0);
        end
        for (int c = 1; c <= done_c; c++) begin
            tick;
            ex_valid = 1'b0;
            if (ram && ld && !mis) da_rvalid = (c == 3 + dly);
            else da_rvalid = 1'($urandom_range(0, 1));
            da_rdata = (da_rvalid && ram && ld && !mis) ? word : $urandom;
            if (c >= 2) begin
                mem_ram_addr = $urandom;
                mem_ram_ext_op = 3'($urandom);
                mem_ram_we = 4'($urandom);
            end
            smp;
            chk("done", mem_done, ram && c == done_c);
            chk("stall", mem_stall, ram && c < done_c);
        end
        ale_exp = 1'b0;
        if (ram) begin
            if (mis) begin
`ifdef MEM_RESP_ALE_EN
                ale_exp = 1'b1;
                exp_badv = a;
`else
                if (ld) exp_rdata = '0;
`endif
            end else if (ld) begin
                exp_rdata = ref_load(e, a, word);
                exp_cnt = (dly + 1 > 255) ? 8'd255 : 8'(dly + 1);
            end
        end
        chk("rdata", mem_rdata, exp_rdata);
        chk("wait_cnt", ld_wait_cnt, exp_cnt);
        chk("ale", mem_ale, ale_exp);
        chk("badv", mem_badv, exp_badv);
        da_rvalid = 1'b0;
    endtask

    initial begin
        logic [2:0] exts [5];
        logic [3:0] wes [3];
        exts = '{RAM_EXT_W, RAM_EXT_B, RAM_EXT_BU, RAM_EXT_H, RAM_EXT_HU};
        wes  = '{RAM_WE_B, RAM_WE_H, RAM_WE_W};

        tick; tick;
        smp;
        chk("rst_done", mem_done, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_ale", mem_ale, 0);
        chk("rst_badv", mem_badv, 0);
        chk("rst_cnt", ld_wait_cnt, 0);
        tick;
        rst = 1'b0;

        access(WD_RAM, RAM_EXT_B,  RAM_WE_N, 32'h1003, 32'h80AA_BBCC, 0, 0);
        chk("ldb_val", mem_rdata, 32'hFFFF_FF80);
        access(WD_RAM, RAM_EXT_HU, RAM_WE_N, 32'h2002, 32'h8001_1234, 4, 0);
        chk("ldhu_val", mem_rdata, 32'h0000_8001);
        chk("ldhu_cnt", ld_wait_cnt, 8'd5);
        access(WD_RAM, RAM_EXT_W,  RAM_WE_W, 32'h3000, 32'h0, 0, 0);
        access(WD_RAM, RAM_EXT_W,  RAM_WE_N, 32'h4002, 32'h1234_5678, 0, 0);
        access(WD_RAM, RAM_EXT_H,  RAM_WE_N, 32'h10, 32'h8000_7FFF, 0, 0);
        chk("b2b_first", mem_rdata, 32'h0000_7FFF);
        access(WD_RAM, RAM_EXT_H,  RAM_WE_N, 32'h12, 32'h8000_7FFF, 1, 1);
        chk("b2b_second", mem_rdata, 32'hFFFF_8000);
        access(WD_RAM, RAM_EXT_W,  RAM_WE_N, 32'h20, 32'hCAFE_F00D, 300, 0);

        for (int i = 0; i < 150; i++) begin
            logic [1:0] wd;
            logic [3:0] w;
            wd = ($urandom_range(0, 5) == 0) ? 2'b10 : WD_RAM;
            w  = ($urandom_range(0, 1) == 0) ? RAM_WE_N : wes[$urandom_range(0, 2)];
            access(wd, exts[$urandom_range(0, 4)], w, $urandom, $urandom,
                   $urandom_range(0, 6), 1'($urandom_range(0, 1)));
        end

        // Make sure the reset below visibly clears a nonzero result.
        access(WD_RAM, RAM_EXT_W, RAM_WE_N, 32'h40, 32'hDEAD_BEEF, 0, 0);
        tick;
        ex_valid = 1'b1; mem_wd_sel = WD_RAM; mem_ram_ext_op = RAM_EXT_W;
        mem_ram_we = RAM_WE_N; mem_ram_addr = 32'h50;
        tick; ex_valid = 1'b0;
        tick; tick;
        rst = 1'b1; da_rvalid = 1'b1; da_rdata = 32'h1111_2222;
        tick;
        rst = 1'b0; da_rdata = 32'h3333_4444;
        smp;
        chk("rstld_done", mem_done, 0);
        chk("rstld_stall", mem_stall, 0);
        chk("rstld_rdata", mem_rdata, 0);
        tick;
        da_rvalid = 1'b0;
        smp;
        chk("stray_done", mem_done, 0);
        chk("stray_rdata", mem_rdata, 0);
        chk("stray_ale", mem_ale, 0);
        chk("stray_badv", mem_badv, 0);
        chk("stray_cnt", ld_wait_cnt, 0);
        exp_rdata = '0; exp_cnt = '0; exp_badv = '0;
        access(WD_RAM, RAM_EXT_BU, RAM_WE_N, 32'h61, 32'h0000_9A00, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_resp.md
# mem_resp

Load/store completion stage of the MEM pipeline segment, directly downstream of the memory request issuer. Tracks each access the issuer sends on the data bus, waits for the load response, and aligns and extends the returned word into write-back data. Holds the pipeline with a stall while an access is outstanding. Detects misaligned accesses that the issuer suppresses, so the pipeline never waits for a response that will never come.

## Interface
Parameters:
- TIMEOUT_W, 8: width of the outstanding-load cycle counter (debug visibility only).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX stage handing an instruction to MEM this cycle (same signal the issuer samples).
- mem_wd_sel  in  2  write-back select; `WD_RAM` marks a memory access.
- mem_ram_addr  in  32  byte address of the access.
- mem_ram_ext_op  in  3  load type (`RAM_EXT_*`).
- mem_ram_we  in  4  store type (`RAM_WE_*`); `RAM_WE_N` (4'h0) means load.
- da_rvalid  in  1  data bus read data valid, single-cycle pulse.
- da_rdata  in  32  data bus read word, word aligned.
- mem_rdata  out  32  aligned, extended load result; held until the next completion.
- mem_done  out  1  one-cycle pulse: access completed.
- mem_stall  out  1  hold the upstream pipeline.
- mem_ale  out  1  misaligned-access flag, valid with mem_done.
- mem_badv  out  32  faulting address, valid with mem_ale.
- ld_wait_cnt  out  TIMEOUT_W  cycles the current load has waited, saturating.

## Operation
- start is ex_valid registered. It marks the first MEM cycle and matches the issuer's internal request pulse.
- In the start cycle with mem_wd_sel==`WD_RAM`, capture ext_op, we, addr[1:0], and addr into a context register.
- Misalignment:
  - B and BU loads, and byte stores: never misaligned.
  - H and HU loads, and half stores: misaligned when addr[0]=1.
  - W loads and word stores: misaligned when addr[1:0]!=0.
- FSM states:
  - IDLE: start and RAM and misaligned → ERR. Start and RAM and store → ST. Start and RAM and load → LD. Otherwise stay in IDLE.
  - ST: one cycle while the issuer drives da_wen → IDLE, pulse mem_done.
  - LD: wait for da_rvalid. Increment ld_wait_cnt each cycle, saturating at all-ones. On da_rvalid, register the extracted data → IDLE, pulse mem_done.
  - ERR: one cycle → IDLE, pulse mem_done with mem_ale=1 and mem_badv=captured addr. mem_rdata is not updated.
- Extraction uses byte lane = off, half lane = off[1].
  - B: sign-extend the byte. BU: zero-extend the byte.
  - H: sign-extend the half. HU: zero-extend the half.
  - Default: the whole word.
- mem_stall = (start & RAM) | (state!=IDLE). It drops in the same cycle mem_done pulses.
- da_rvalid outside LD is ignored.
- A start while state!=IDLE is a protocol error and is ignored.

## Timing
- Reset values: state=IDLE, mem_rdata=0, mem_done=0, mem_ale=0, mem_badv=0, ld_wait_cnt=0, start=0.
- Latency:
  - ex_valid at T, start at T+1, issuer drives da_ren at T+2, earliest da_rvalid at T+3.
  - mem_done at T+(rvalid cycle−T)+1, so minimum T+4.
  - Store: mem_done at T+3. ERR: mem_done at T+3.
- Reset mid-LD: return to IDLE, drop the context, and ignore the late da_rvalid.
- da_rvalid in the same cycle as rst: rst wins.
- Back-to-back accesses: a new ex_valid may arrive in the cycle mem_done pulses. Its start lands one cycle later.

## Configuration
- MEM_RESP_ALE_EN defined: misaligned accesses raise mem_ale and mem_badv as described.
- MEM_RESP_ALE_EN undefined: misaligned accesses still take the ERR path, so there is no hang, but mem_ale is tied to 0 and mem_badv to 0. Misaligned loads write mem_rdata=0.

## Structure
- Encodings live in the shared defines header, defines.vh: `WD_RAM`=2'b01, `RAM_EXT_W`=3'b000, `RAM_EXT_B`=3'b001, `RAM_EXT_BU`=3'b010, `RAM_EXT_H`=3'b011, `RAM_EXT_HU`=3'b100, `RAM_WE_N`=4'h0, `RAM_WE_B`=4'h1, `RAM_WE_H`=4'h3, `RAM_WE_W`=4'hF.
- FSM state codes are localparams in this module.
- One sub-module, load_align: combinational lane select plus extension (ext_op, off, word → result), reusable by the cache refill path.

## Test plan
- ld.b at addr 0x1003, rdata 0x80AA_BBCC with rvalid 1 cycle after ren → mem_rdata 0xFFFF_FF80, mem_done at T+4, stall high T+1..T+3.
- ld.hu at addr 0x2002, rdata 0x8001_1234 with rvalid delayed 5 cycles → mem_rdata 0x0000_8001, ld_wait_cnt reaches 5, stall held throughout.
- st.w at addr 0x3000 → mem_done at T+3, no dependency on rvalid, mem_rdata unchanged.
- ld.w at addr 0x4002 with ALE_EN → mem_done at T+3, mem_ale=1, mem_badv 0x4002. Without ALE_EN → mem_ale=0, mem_rdata=0.
- rst asserted while in LD, then a stray rvalid next cycle → no mem_done, all outputs at reset values.
- Two back-to-back ld.h (0x10 then 0x12) on one word 0x8000_7FFF → results 0x0000_7FFF then 0xFFFF_8000, both completing.
